route_sched: RTL and testbench

ROUTE_SCHED -- requirements
Module: route_sched

---
 rtl/route_sched.sv | 100 ++++++++++
 tb/tb_route_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/route_sched.sv
// Round-robin route scheduler: grants one of four sources a fixed-length path
// through a downstream mux/demux router, with one dead cycle between routes.
module route_sched #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [7:0]         dest_cfg,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         muxaddr,
  output logic [1:0]         dmuxaddr,
  output logic               route_en,
  output logic [3:0]         gnt,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         mux_q, mux_d;
  logic [1:0]         dmux_q, dmux_d;
  logic [2:0]         pick;
  logic [DWELL_W-1:0] dwell_eff;

  // Returns {found, index}; scanning from the far end lets the first source
  // in the order ptr+1, ptr+2, ptr+3, ptr overwrite the later candidates.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = p + i[1:0];
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign pick      = rr_pick(req, ptr_q);
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    mux_d    = mux_q;
    dmux_d   = dmux_q;
    route_en = 1'b0;
    gnt      = 4'b0000;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick[2]) begin
          state_d = HOLD;
          ptr_d   = pick[1:0];
          mux_d   = pick[1:0];
          dmux_d  = dest_cfg[2*pick[1:0] +: 2];
          cnt_d   = dwell_eff;
        end
      end
      HOLD: begin
        route_en = 1'b1;
        gnt      = 4'b0001 << mux_q;
        busy     = 1'b1;
        cnt_d    = cnt_q - DWELL_W'(1);
        if (cnt_q <= DWELL_W'(1)) state_d = GAP;
      end
      GAP: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to 3 so the first search after reset starts at source 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      mux_q   <= 2'd0;
      dmux_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      mux_q   <= mux_d;
      dmux_q  <= dmux_d;
    end
  end

  assign muxaddr  = mux_q;
  assign dmuxaddr = dmux_q;

endmodule

// File: tb/tb_route_sched.sv
// Bench for route_sched: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural schedule model.
module tb_route_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] dest_cfg = 8'h00;
  logic [3:0] dwell = 4'd0;
  logic [1:0] muxaddr, dmuxaddr;
  logic       route_en, busy;
  logic [3:0] gnt;

  route_sched #(.DWELL_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dest_cfg (dest_cfg),
    .dwell    (dwell),
    .muxaddr  (muxaddr),
    .dmuxaddr (dmuxaddr),
    .route_en (route_en),
    .gnt      (gnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: cycles of route left, pending dead cycle, last winner, latched selects.
  int m_left = 0;
  bit m_gap  = 1'b0;
  int m_ptr  = 3;
  int m_mux  = 0;
  int m_dmux = 0;
  int m_len  = 0;

  int         run_len = 0;
  bit         prev_en = 1'b0;
  logic [1:0] prev_mux = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_left = 0; m_gap = 1'b0; m_ptr = 3; m_mux = 0; m_dmux = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_gap = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (req[c]) begin
          m_ptr  = c;
          m_mux  = c;
          m_dmux = dest_cfg[2*c +: 2];
          m_left = (dwell == 0) ? 1 : int'(dwell);
          m_len  = m_left;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    bit r;
    @(posedge clk);
    r = rst;
    model_edge();
    #1;
    chk("route_en", route_en, m_left > 0);
    chk("gnt", gnt, (m_left > 0) ? (1 << m_mux) : 0);
    chk("muxaddr", muxaddr, m_mux);
    chk("dmuxaddr", dmuxaddr, m_dmux);
    chk("busy", busy, (m_left > 0) || m_gap);
    chk("gnt_onehot_iff_en", $onehot(gnt), route_en);
    if (route_en && prev_en) chk("no_back_to_back", muxaddr, prev_mux);
    if (r) run_len = 0;
    else if (route_en) run_len++;
    else if (prev_en) begin
      chk("route_len", run_len, m_len);
      run_len = 0;
    end
    prev_en  = route_en;
    prev_mux = muxaddr;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_mux", muxaddr, 0);
    chk("rst_dmux", dmuxaddr, 0);
    chk("rst_en", route_en, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single source 1 routed to output 3 for three cycles
    req = 4'b0010; dest_cfg = 8'b11_00_11_00; dwell = 4'd3;
    tick();
    chk("t028_mux", muxaddr, 1);
    chk("t028_dmux", dmuxaddr, 3);
    chk("t028_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick(); tick();
    chk("t028_en3", route_en, 1);
    tick();
    chk("t028_gap_en", route_en, 0);
    chk("t028_gap_busy", busy, 1);
    tick();
    chk("t028_idle_busy", busy, 0);

    // All requesting, dwell 1: round-robin from source 0
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; dwell = 4'd1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t029_order", muxaddr, g % 4);
      chk("t029_hold", route_en, 1);
      tick();
      chk("t029_gap", route_en, 0);
      tick();
      chk("t029_idle", {route_en, busy}, 2'b00);
    end
    req = 4'b0000;

    // Dwell 0 behaves as 1
    req = 4'b1000; dest_cfg = 8'b00_11_10_01; dwell = 4'd0;
    tick();
    chk("t030_mux", muxaddr, 3);
    chk("t030_dmux", dmuxaddr, 0);
    chk("t030_en", route_en, 1);
    req = 4'b0000;
    tick();
    chk("t030_off", route_en, 0);
    tick();

    // Config changes and request drop mid-route are ignored
    req = 4'b0100; dest_cfg = 8'b00_10_00_00; dwell = 4'd5;
    tick();
    chk("t031_mux", muxaddr, 2);
    chk("t031_dmux", dmuxaddr, 2);
    tick(); tick();
    dest_cfg = 8'hFF; req = 4'b0000; dwell = 4'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t031_en", route_en, 1);
      chk("t031_dmux_held", dmuxaddr, 2);
    end
    tick();
    chk("t031_end", route_en, 0);
    tick();

    // Reset in the second HOLD cycle
    req = 4'b0001; dwell = 4'd4; dest_cfg = 8'b01_01_01_11;
    tick(); tick();
    rst = 1'b1; req = 4'b1111; dwell = 4'd2;
    tick();
    chk("t032_en", route_en, 0);
    chk("t032_gnt", gnt, 0);
    chk("t032_mux", muxaddr, 0);
    chk("t032_dmux", dmuxaddr, 0);
    chk("t032_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("t032_first", muxaddr, 0);
    chk("t032_first_gnt", gnt, 4'b0001);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      req      = 4'($urandom);
      dest_cfg = 8'($urandom);
      dwell    = 4'($urandom_range(0, 6));
      rst      = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0; req = 4'b0000;
    repeat (10) tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
